// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: issue/collect stage in front of the iterative multiplier
// and divider. Latches one request, fires a single start pulse to the selected
// unit, waits for its ready (with a hung-unit timeout) and holds the captured
// result until the consumer acknowledges it.
module multdiv_sequencer #(
   parameter int unsigned TIMEOUT = 40,
   parameter int unsigned CNT_W   = 6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        op_valid,
   input  logic        op_is_mult,
   input  logic        op_is_div,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic [4:0]  op_dest,
   output logic [31:0] unit_operandA,
   output logic [31:0] unit_operandB,
   output logic        ctrl_MULT,
   output logic        ctrl_DIV,
   input  logic [31:0] mult_result,
   input  logic        mult_exception,
   input  logic        mult_resultRDY,
   input  logic [31:0] div_result,
   input  logic        div_exception,
   input  logic        div_resultRDY,
   output logic        stall,
   output logic        result_valid,
   output logic [31:0] result,
   output logic        result_exception,
   output logic [4:0]  result_dest,
   input  logic        result_ack
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] counter;
   logic             sel_mult;
   logic [4:0]       dest_q;

   logic             accept;
   logic             capture;
   logic             timed_out;
   logic             unit_rdy;
   logic             unit_exc;
   logic [31:0]      unit_res;

   // Last WAIT cycle: counter holds TIMEOUT-1, so the wait lasts TIMEOUT cycles.
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

   assign stall = (state != S_IDLE);

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state decode plus selected-unit response mux.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      capture   = 1'b0;
      timed_out = 1'b0;
      unit_rdy  = sel_mult ? mult_resultRDY : div_resultRDY;
      unit_exc  = sel_mult ? mult_exception : div_exception;
      unit_res  = sel_mult ? mult_result    : div_result;
      case (state)
         S_IDLE: begin
            if (op_valid && (op_is_mult || op_is_div)) begin
               accept    = 1'b1;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT: begin
            // counter==0 masks a stale ready left high by the previous operation
            if ((counter != '0) && unit_rdy) begin
               capture   = 1'b1;
               state_nxt = S_DONE;
            end else if (counter == LAST_WAIT) begin
               timed_out = 1'b1;
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (result_ack) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Operand latch, start pulses, wait counter and result register.
   always_ff @(posedge clock) begin
      if (reset) begin
         unit_operandA    <= '0;
         unit_operandB    <= '0;
         ctrl_MULT        <= 1'b0;
         ctrl_DIV         <= 1'b0;
         counter          <= '0;
         sel_mult         <= 1'b0;
         dest_q           <= '0;
         result_valid     <= 1'b0;
         result           <= '0;
         result_exception <= 1'b0;
         result_dest      <= '0;
      end else begin
         ctrl_MULT <= 1'b0;
         ctrl_DIV  <= 1'b0;
         if (accept) begin
            unit_operandA <= op_a;
            unit_operandB <= op_b;
            dest_q        <= op_dest;
            sel_mult      <= op_is_mult;
            ctrl_MULT     <= op_is_mult;
            ctrl_DIV      <= ~op_is_mult;
         end
         if (state == S_ISSUE)     counter <= '0;
         else if (state == S_WAIT) counter <= counter + 1'b1;
         if (capture) begin
            result           <= unit_exc ? '0 : unit_res;
            result_exception <= unit_exc;
            result_dest      <= dest_q;
            result_valid     <= 1'b1;
         end else if (timed_out) begin
            result           <= '0;
            result_exception <= 1'b1;
            result_dest      <= dest_q;
            result_valid     <= 1'b1;
         end
         if ((state == S_DONE) && result_ack) result_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: stub units answer with scripted
// results; expected results go into a scoreboard queue at issue time and are
// popped when result_valid rises.
module tb_multdiv_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        op_valid, op_is_mult, op_is_div;
   logic [31:0] op_a, op_b;
   logic [4:0]  op_dest;
   logic [31:0] unit_operandA, unit_operandB;
   logic        ctrl_MULT, ctrl_DIV;
   logic [31:0] mult_result, div_result;
   logic        mult_exception, mult_resultRDY, div_exception, div_resultRDY;
   logic        stall, result_valid, result_exception, result_ack;
   logic [31:0] result;
   logic [4:0]  result_dest;

   typedef struct {
      logic [31:0] res;
      logic        exc;
      logic [4:0]  dest;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   mult_pulses = 0;
   int   div_pulses = 0;

   multdiv_sequencer #(.TIMEOUT(40), .CNT_W(6)) dut (
      .clock(clock), .reset(reset),
      .op_valid(op_valid), .op_is_mult(op_is_mult), .op_is_div(op_is_div),
      .op_a(op_a), .op_b(op_b), .op_dest(op_dest),
      .unit_operandA(unit_operandA), .unit_operandB(unit_operandB),
      .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
      .mult_result(mult_result), .mult_exception(mult_exception),
      .mult_resultRDY(mult_resultRDY),
      .div_result(div_result), .div_exception(div_exception),
      .div_resultRDY(div_resultRDY),
      .stall(stall), .result_valid(result_valid), .result(result),
      .result_exception(result_exception), .result_dest(result_dest),
      .result_ack(result_ack)
   );

   always #5 clock = ~clock;

   // Independent start-pulse counters, sampled mid-cycle.
   always @(negedge clock) begin
      if (ctrl_MULT) mult_pulses++;
      if (ctrl_DIV)  div_pulses++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_rdy(input logic m, input logic rdy, input logic [31:0] res,
                          input logic exc);
      if (m) begin
         mult_resultRDY = rdy; mult_result = res; mult_exception = exc;
      end else begin
         div_resultRDY = rdy; div_result = res; div_exception = exc;
      end
   endtask

   task automatic check_result(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 1, 0);
      end else begin
         e = sb.pop_front();
         chk({tag, "_valid"}, result_valid, 1'b1);
         chk({tag, "_res"},   result, e.res);
         chk({tag, "_exc"},   result_exception, e.exc);
         chk({tag, "_dest"},  result_dest, e.dest);
      end
   endtask

   // Release with result_ack, probing that op_valid is ignored in DONE.
   task automatic hold_and_ack(input string tag, input int ack_delay);
      logic [31:0] held_res;
      logic        held_exc;
      held_res = result;
      held_exc = result_exception;
      for (int i = 0; i < ack_delay; i++) begin
         op_valid = 1'b1; op_is_mult = 1'b1; op_is_div = 1'b1;
         step();
         chk({tag, "_hold_valid"}, result_valid, 1'b1);
         chk({tag, "_hold_res"},   {result_exception, result}, {held_exc, held_res});
         chk({tag, "_hold_stall"}, stall, 1'b1);
      end
      op_valid = 1'b0; op_is_mult = 1'b0; op_is_div = 1'b0;
      result_ack = 1'b1;
      step();
      result_ack = 1'b0;
      chk({tag, "_ack_valid"}, result_valid, 1'b0);
      chk({tag, "_ack_stall"}, stall, 1'b0);
   endtask

   // One full operation; unit answers in WAIT cycle (1 + rdy_delay).
   task automatic do_op(input string tag, input logic m, input logic d,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] dest,
                        input logic [31:0] u_res, input logic u_exc,
                        input logic [31:0] e_res, input logic e_exc,
                        input int rdy_delay, input int ack_delay);
      int   mp0, dp0;
      logic sel;
      mp0 = mult_pulses;
      dp0 = div_pulses;
      sel = m;
      op_valid = 1'b1; op_is_mult = m; op_is_div = d;
      op_a = a; op_b = b; op_dest = dest;
      sb.push_back('{res: e_res, exc: e_exc, dest: dest});
      step();                                   // ISSUE
      op_valid = 1'b0; op_is_mult = 1'b0; op_is_div = 1'b0;
      op_a = $urandom; op_b = $urandom; op_dest = 5'(~dest);
      chk({tag, "_pulse_mult"}, ctrl_MULT, sel);
      chk({tag, "_pulse_div"},  ctrl_DIV, !sel);
      chk({tag, "_stall"},      stall, 1'b1);
      chk({tag, "_opA"},        unit_operandA, a);
      set_rdy(!sel, 1'b1, 32'hCAFE_F00D, 1'b1); // other unit noise all along
      step();                                   // WAIT, counter 0
      chk({tag, "_pulse_end"},  {ctrl_MULT, ctrl_DIV}, 2'b00);
      chk({tag, "_opB"},        unit_operandB, b);
      set_rdy(sel, 1'b1, 32'h0BAD_0BAD, 1'b0);  // stale ready, must be masked
      step();                                   // WAIT, counter 1
      set_rdy(sel, 1'b0, 32'h0, 1'b0);
      chk({tag, "_stale_masked"}, result_valid, 1'b0);
      for (int i = 0; i < rdy_delay; i++) begin
         step();
         chk({tag, "_early"}, result_valid, 1'b0);
      end
      set_rdy(sel, 1'b1, u_res, u_exc);
      step();
      set_rdy(sel, 1'b0, 32'h0, 1'b0);
      set_rdy(!sel, 1'b0, 32'h0, 1'b0);
      check_result(tag);
      hold_and_ack(tag, ack_delay);
      chk({tag, "_nmult_pulses"}, mult_pulses - mp0, sel ? 1 : 0);
      chk({tag, "_ndiv_pulses"},  div_pulses - dp0,  sel ? 0 : 1);
   endtask

   initial begin : stim
      int n;
      int mp0, dp0;
      reset = 1'b1;
      op_valid = 1'b0; op_is_mult = 1'b0; op_is_div = 1'b0;
      op_a = '0; op_b = '0; op_dest = '0;
      mult_result = '0; mult_exception = 1'b0; mult_resultRDY = 1'b0;
      div_result = '0;  div_exception = 1'b0;  div_resultRDY = 1'b0;
      result_ack = 1'b0;
      step(); step();
      reset = 1'b0;
      chk("rst_outs", {unit_operandA, unit_operandB, ctrl_MULT, ctrl_DIV, stall,
                       result_valid, result, result_exception, result_dest}, '0);

      // Ignored request: neither flag set.
      mp0 = mult_pulses; dp0 = div_pulses;
      op_valid = 1'b1;
      step();
      op_valid = 1'b0;
      chk("noflag_stall", stall, 1'b0);
      step();
      chk("noflag_pulses", mult_pulses + div_pulses - mp0 - dp0, 0);

      do_op("mul_pos", 1'b1, 1'b0, 32'd7, 32'd3, 5'd5,
            32'h0000_0015, 1'b0, 32'h0000_0015, 1'b0, 3, 0);
      do_op("mul_neg", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 5'd17,
            32'hFFFF_FFEB, 1'b0, 32'hFFFF_FFEB, 1'b0, 2, 10);
      do_op("div_norm", 1'b0, 1'b1, 32'd100, 32'd7, 5'd9,
            32'd14, 1'b0, 32'd14, 1'b0, 5, 1);
      do_op("div_zero", 1'b0, 1'b1, 32'd5, 32'd0, 5'd30,
            32'hDEAD_BEEF, 1'b1, 32'd0, 1'b1, 0, 0);
      do_op("mul_ovf", 1'b1, 1'b0, 32'h4000_0000, 32'd4, 5'd31,
            32'h1234_5678, 1'b1, 32'd0, 1'b1, 31, 2);
      do_op("both_flags", 1'b1, 1'b1, 32'd6, 32'd6, 5'd1,
            32'd36, 1'b0, 32'd36, 1'b0, 1, 0);
      do_op("last_wait", 1'b0, 1'b1, 32'hFFFF_FF9C, 32'd10, 5'd12,
            32'hFFFF_FFF6, 1'b0, 32'hFFFF_FFF6, 1'b0, 38, 0);

      // Hung multiplier: only the divider reports ready.
      mp0 = mult_pulses;
      op_valid = 1'b1; op_is_mult = 1'b1; op_is_div = 1'b0;
      op_a = 32'd3; op_b = 32'd3; op_dest = 5'd22;
      sb.push_back('{res: 32'd0, exc: 1'b1, dest: 5'd22});
      step();
      op_valid = 1'b0; op_is_mult = 1'b0;
      div_resultRDY = 1'b1; div_result = 32'h5555_5555;
      n = 0;
      while (!result_valid && n < 60) begin
         step();
         n++;
      end
      div_resultRDY = 1'b0;
      chk("tmo_cycles", n, 41);
      check_result("tmo");
      hold_and_ack("tmo", 0);
      chk("tmo_pulses", mult_pulses - mp0, 1);

      // Reset in the fifth WAIT cycle abandons the operation.
      op_valid = 1'b1; op_is_mult = 1'b0; op_is_div = 1'b1;
      op_a = 32'd50; op_b = 32'd5; op_dest = 5'd7;
      step();                                   // ISSUE
      op_valid = 1'b0; op_is_div = 1'b0;
      for (int i = 0; i < 5; i++) step();       // WAIT counter 0..4
      chk("pre_rst_stall", stall, 1'b1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midrst_outs", {unit_operandA, unit_operandB, ctrl_MULT, ctrl_DIV, stall,
                          result_valid, result, result_exception, result_dest}, '0);
      mp0 = mult_pulses; dp0 = div_pulses;
      div_resultRDY = 1'b1; div_result = 32'd10;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("postrst_idle", {stall, result_valid}, 2'b00);
      end
      div_resultRDY = 1'b0;
      chk("postrst_pulses", mult_pulses + div_pulses - mp0 - dp0, 0);

      do_op("after_rst", 1'b0, 1'b1, 32'd50, 32'd5, 5'd7,
            32'd10, 1'b0, 32'd10, 1'b0, 4, 0);
      chk("sb_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
